nios2_gen2_cpu_div_cell: RTL and testbench

- Iterative radix-2 restoring divider. It is the inverse-operation companion to the CPU multiply cell.
- Accepts two 32-bit operands from the E stage and produces quotient and remainder after a fixed latency.
- Supports signed (DIV) and unsigned (DIVU). The pipeline stalls on div_busy and retires on div_done.

---
 rtl/nios2_gen2_cpu_div_cell.sv | 131 +++++++++++++
 tb/tb_nios2_gen2_cpu_div_cell.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_gen2_cpu_div_cell.sv
// Iterative radix-2 restoring divider for the CPU E stage.
// One quotient bit per cycle on operand magnitudes, then a single fixup cycle
// that applies signs and publishes the quotient and remainder.
//
//   state | meaning
//   IDLE  | waiting for a start request
//   RUN   | WIDTH shift/trial-subtract iterations
//   FIXUP | sign correction, results registered
//   DONE  | div_done pulse; a start here chains into RUN with no bubble
module nios2_gen2_cpu_div_cell #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             E_div_start,
   input  logic             E_div_signed,
   input  logic [WIDTH-1:0] E_src1,
   input  logic [WIDTH-1:0] E_src2,
   input  logic             E_div_abort,
   output logic             div_busy,
   output logic             div_done,
   output logic [WIDTH-1:0] div_quot,
   output logic [WIDTH-1:0] div_rem,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] prem;     // partial remainder; its extra top bit only exists in 'shifted'
   logic [WIDTH-1:0] dvd;      // dividend magnitude, becomes the quotient magnitude
   logic [WIDTH-1:0] dvs;      // divisor magnitude
   logic [CNT_W-1:0] cnt;
   logic             quot_neg;
   logic             rem_neg;
   logic             zero_div;

   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Operand magnitudes at start and the per-iteration trial subtraction.
   // A non-negative trial is always < divisor, so its low WIDTH bits hold it exactly.
   always_comb begin
      mag1    = (E_div_signed && E_src1[WIDTH-1]) ? (WIDTH'(0) - E_src1) : E_src1;
      mag2    = (E_div_signed && E_src2[WIDTH-1]) ? (WIDTH'(0) - E_src2) : E_src2;
      shifted = {prem, dvd[WIDTH-1]};
      trial   = shifted - {1'b0, dvs};
   end

   // Sequencing FSM with datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         div_busy    <= 1'b0;
         div_done    <= 1'b0;
         div_quot    <= '0;
         div_rem     <= '0;
         div_by_zero <= 1'b0;
         prem        <= '0;
         dvd         <= '0;
         dvs         <= '0;
         cnt         <= '0;
         quot_neg    <= 1'b0;
         rem_neg     <= 1'b0;
         zero_div    <= 1'b0;
      end else begin
         div_done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (E_div_start) begin
                  dvd      <= mag1;
                  dvs      <= mag2;
                  prem     <= '0;
                  cnt      <= '0;
                  zero_div <= (E_src2 == '0);
                  quot_neg <= E_div_signed & (E_src1[WIDTH-1] ^ E_src2[WIDTH-1]);
                  rem_neg  <= E_div_signed & E_src1[WIDTH-1];
                  div_busy <= 1'b1;
                  state    <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (E_div_abort) begin
                  div_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  if (!trial[WIDTH]) begin
                     prem <= trial[WIDTH-1:0];
                     dvd  <= {dvd[WIDTH-2:0], 1'b1};
                  end else begin
                     prem <= shifted[WIDTH-1:0];
                     dvd  <= {dvd[WIDTH-2:0], 1'b0};
                  end
                  if (cnt == LAST_ITER) begin
                     state <= FIXUP;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            FIXUP: begin
               div_busy <= 1'b0;
               if (E_div_abort) begin
                  state <= IDLE;
               end else begin
                  // Zero divisor forces an all-ones quotient regardless of sign;
                  // the remainder already equals the dividend magnitude, so the
                  // sign fixup restores the original dividend.
                  div_quot    <= zero_div ? '1 : (quot_neg ? (WIDTH'(0) - dvd) : dvd);
                  div_rem     <= rem_neg ? (WIDTH'(0) - prem) : prem;
                  div_by_zero <= zero_div;
                  div_done    <= 1'b1;
                  state       <= DONE;
               end
            end
            default: begin
               div_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nios2_gen2_cpu_div_cell.sv
// Directed bench for the iterative divider: latency, signs, zero divisor,
// overflow, abort, busy start, back-to-back and mid-operation reset.
module tb_nios2_gen2_cpu_div_cell;

   logic        clk = 1'b0;
   logic        reset;
   logic        E_div_start;
   logic        E_div_signed;
   logic [31:0] E_src1;
   logic [31:0] E_src2;
   logic        E_div_abort;
   logic        div_busy;
   logic        div_done;
   logic [31:0] div_quot;
   logic [31:0] div_rem;
   logic        div_by_zero;

   int vectors = 0;
   int errors  = 0;

   nios2_gen2_cpu_div_cell #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .E_div_start  (E_div_start),
      .E_div_signed (E_div_signed),
      .E_src1       (E_src1),
      .E_src2       (E_src2),
      .E_div_abort  (E_div_abort),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .div_quot     (div_quot),
      .div_rem      (div_rem),
      .div_by_zero  (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a start now (caller sits at a negedge), then watch up to 40 cycles.
   task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output int done_at, output logic done_busy);
      E_div_signed = sg;
      E_src1       = a;
      E_src2       = b;
      E_div_start  = 1'b1;
      @(posedge clk);
      #1 E_div_start = 1'b0;
      busy_cnt  = 0;
      done_at   = -1;
      done_busy = 1'bx;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (div_busy) busy_cnt++;
         if (div_done) begin
            done_at   = i;
            done_busy = div_busy;
            break;
         end
      end
   endtask

   int   bc;
   int   da;
   logic db;
   logic seen;

   initial begin
      reset        = 1'b1;
      E_div_start  = 1'b0;
      E_div_signed = 1'b0;
      E_src1       = '0;
      E_src2       = '0;
      E_div_abort  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(div_busy), 32'd0);
      check("rst_done", 32'(div_done), 32'd0);
      check("rst_quot", div_quot, 32'd0);
      check("rst_rem",  div_rem,  32'd0);
      check("rst_dbz",  32'(div_by_zero), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // unsigned 100/7
      do_op(1'b0, 32'd100, 32'd7, bc, da, db);
      check("u100_7_lat",   32'(da), 32'd34);
      check("u100_7_busy",  32'(bc), 32'd33);
      check("u100_7_dbusy", 32'(db), 32'd0);
      check("u100_7_quot",  div_quot, 32'd14);
      check("u100_7_rem",   div_rem,  32'd2);
      check("u100_7_dbz",   32'(div_by_zero), 32'd0);

      // back-to-back from the DONE cycle
      do_op(1'b0, 32'd1000, 32'd10, bc, da, db);
      check("b2b_lat",  32'(da), 32'd34);
      check("b2b_quot", div_quot, 32'd100);
      check("b2b_rem",  div_rem,  32'd0);
      @(negedge clk);
      check("done_single", 32'(div_done), 32'd0);

      // signed -7/2 -> -3 r -1
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, bc, da, db);
      check("s_m7_2_quot", div_quot, 32'hFFFF_FFFD);
      check("s_m7_2_rem",  div_rem,  32'hFFFF_FFFF);
      @(negedge clk);

      // signed 7/-2 -> -3 r 1
      do_op(1'b1, 32'd7, 32'hFFFF_FFFE, bc, da, db);
      check("s_7_m2_quot", div_quot, 32'hFFFF_FFFD);
      check("s_7_m2_rem",  div_rem,  32'd1);
      @(negedge clk);

      // unsigned 0xFFFFFFF9/2
      do_op(1'b0, 32'hFFFF_FFF9, 32'd2, bc, da, db);
      check("u_big_quot", div_quot, 32'h7FFF_FFFC);
      check("u_big_rem",  div_rem,  32'd1);
      @(negedge clk);

      // unsigned 5/0
      do_op(1'b0, 32'd5, 32'd0, bc, da, db);
      check("u_dz_lat",  32'(da), 32'd34);
      check("u_dz_quot", div_quot, 32'hFFFF_FFFF);
      check("u_dz_rem",  div_rem,  32'd5);
      check("u_dz_dbz",  32'(div_by_zero), 32'd1);
      @(negedge clk);

      // signed -5/0: remainder keeps the negative dividend
      do_op(1'b1, 32'hFFFF_FFFB, 32'd0, bc, da, db);
      check("s_dz_quot", div_quot, 32'hFFFF_FFFF);
      check("s_dz_rem",  div_rem,  32'hFFFF_FFFB);
      check("s_dz_dbz",  32'(div_by_zero), 32'd1);
      @(negedge clk);

      // signed overflow
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, bc, da, db);
      check("ovf_quot", div_quot, 32'h8000_0000);
      check("ovf_rem",  div_rem,  32'd0);
      check("ovf_dbz",  32'(div_by_zero), 32'd0);
      @(negedge clk);

      // abort at k+10
      E_div_signed = 1'b0;
      E_src1       = 32'd50;
      E_src2       = 32'd3;
      E_div_start  = 1'b1;
      @(posedge clk);
      #1 E_div_start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      E_div_abort = 1'b1;
      @(posedge clk);
      #1 E_div_abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(div_busy), 32'd0);
      seen = div_done;
      repeat (40) begin
         @(negedge clk);
         if (div_done) seen = 1'b1;
      end
      check("abort_nodone", 32'(seen), 32'd0);
      check("abort_quot",   div_quot, 32'h8000_0000);
      check("abort_rem",    div_rem,  32'd0);

      // start at k+5 while busy is ignored
      E_src1      = 32'd1000;
      E_src2      = 32'd10;
      E_div_start = 1'b1;
      @(posedge clk);
      #1 E_div_start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      E_src1      = 32'd20;
      E_src2      = 32'd4;
      E_div_start = 1'b1;
      @(posedge clk);
      #1 E_div_start = 1'b0;
      da = -1;
      for (int i = 6; i <= 45; i++) begin
         @(negedge clk);
         if (div_done) begin
            da = i;
            break;
         end
      end
      check("busy_start_lat",  32'(da), 32'd34);
      check("busy_start_quot", div_quot, 32'd100);
      check("busy_start_rem",  div_rem,  32'd0);
      @(negedge clk);

      // reset at k+20
      E_src1      = 32'd123;
      E_src2      = 32'd4;
      E_div_start = 1'b1;
      @(posedge clk);
      #1 E_div_start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mrst_busy", 32'(div_busy), 32'd0);
      check("mrst_done", 32'(div_done), 32'd0);
      check("mrst_quot", div_quot, 32'd0);
      check("mrst_rem",  div_rem,  32'd0);
      check("mrst_dbz",  32'(div_by_zero), 32'd0);
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (div_done || div_busy) seen = 1'b1;
      end
      check("mrst_idle", 32'(seen), 32'd0);
      do_op(1'b0, 32'd123, 32'd4, bc, da, db);
      check("mrst_lat",  32'(da), 32'd34);
      check("mrst_quot", div_quot, 32'd30);
      check("mrst_rem",  div_rem,  32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
